// File: rtl/crc_stream_pkg.sv
// Shared types and byte-enable helpers for the CRC stream blocks.
package crc_stream_pkg;

   localparam int FCS_BYTES = 4;
   localparam int MAX_BYTES = 16;

   typedef enum logic {
      PASS = 1'b0,
      TAIL = 1'b1
   } state_t;

   // Number of set bits in a byte-enable vector (0..MAX_BYTES).
   function automatic logic [4:0] keep_to_count(input logic [MAX_BYTES-1:0] keep);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         cnt = cnt + 5'(keep[i]);
      end
      return cnt;
   endfunction

   // Mask with the lowest n bits set.
   function automatic logic [MAX_BYTES-1:0] count_to_keep(input logic [4:0] n);
      logic [MAX_BYTES-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         mask[i] = (5'(i) < n);
      end
      return mask;
   endfunction

   // True when the enables form one unbroken run starting at bit 0.
   function automatic logic keep_contiguous(input logic [MAX_BYTES-1:0] keep);
      return (keep == count_to_keep(keep_to_count(keep)));
   endfunction

endpackage

// File: rtl/slicing_crc.sv
// Reflected CRC-32 (poly 0xEDB88320) over up to SLICE_LENGTH bytes per cycle.
// Byte i of data is processed before byte i+1; only bytes with valid[i] set
// contribute. reset is a synchronous clear that wins over the update.
module slicing_crc #(
   parameter int          SLICE_LENGTH    = 8,
   parameter logic [31:0] INITIAL_CRC     = 32'hFFFFFFFF,
   parameter bit          INVERT_OUTPUT   = 1'b1,
   parameter bit          REGISTER_OUTPUT = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [8*SLICE_LENGTH-1:0] data,
   input  logic [SLICE_LENGTH-1:0]   valid,
   output logic [31:0]               crc
);

   localparam logic [31:0] POLY = 32'hEDB88320;

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in ^ {24'h0, b};
      for (int j = 0; j < 8; j++) begin
         c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
      return c;
   endfunction

   logic [31:0] crc_q;
   logic [31:0] crc_next;
   logic [31:0] crc_final;

   // Fold every enabled byte of this cycle into the running remainder.
   always_comb begin
      crc_next = crc_q;
      for (int i = 0; i < SLICE_LENGTH; i++) begin
         if (valid[i]) crc_next = crc_byte(crc_next, data[8*i +: 8]);
      end
   end

   assign crc_final = INVERT_OUTPUT ? ~crc_next : crc_next;

   // Running remainder; clear has priority so a new frame starts clean.
   always_ff @(posedge clk) begin
      if (reset) crc_q <= INITIAL_CRC;
      else       crc_q <= crc_next;
   end

   generate
      if (REGISTER_OUTPUT) begin : g_reg
         logic [31:0] crc_r;
         // Optional registered view of the result.
         always_ff @(posedge clk) begin
            if (reset) crc_r <= INVERT_OUTPUT ? ~INITIAL_CRC : INITIAL_CRC;
            else       crc_r <= crc_final;
         end
         assign crc = crc_r;
      end else begin : g_comb
         assign crc = crc_final;
      end
   endgenerate

endmodule

// File: rtl/crc_fcs_inserter.sv
// Appends the 4-byte CRC-32 FCS after the last payload byte of each frame.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; the source holds data/keep/last stable while valid && !ready,
// and ready may depend combinationally on the consumer's ready.
module crc_fcs_inserter
   import crc_stream_pkg::*;
#(
   parameter int          DATA_BYTES  = 8,
   parameter logic [31:0] INITIAL_CRC = 32'hFFFFFFFF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [8*DATA_BYTES-1:0] s_data,
   input  logic [DATA_BYTES-1:0]   s_keep,
   input  logic                    s_valid,
   input  logic                    s_last,
   output logic                    s_ready,
   output logic [8*DATA_BYTES-1:0] m_data,
   output logic [DATA_BYTES-1:0]   m_keep,
   output logic                    m_valid,
   output logic                    m_last,
   input  logic                    m_ready,
   output logic [31:0]             frame_count,
   output logic                    keep_error,
   output state_t                  dbg_state
);

   localparam int DW = 8 * DATA_BYTES;

   function automatic logic [DATA_BYTES-1:0] keep_mask(input logic [4:0] n);
      logic [MAX_BYTES-1:0] full;
      full = count_to_keep(n);
      return full[DATA_BYTES-1:0];
   endfunction

   function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d, input logic [DATA_BYTES-1:0] k);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (k[i]) r[8*i +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic [31:0]             hold_q, hold_d;
   logic [4:0]              tail_q, tail_d;
   logic                    accept, load_en, load;
   logic [DW-1:0]           nxt_data, last_data;
   logic [DATA_BYTES-1:0]   nxt_keep, core_valid;
   logic                    nxt_last, core_reset;
   logic [31:0]             fcs, fcs_sh;
   logic [4:0]              k;

   assign load_en    = !m_valid || m_ready;
   assign s_ready    = reset && (state_q == PASS) && load_en;
   assign accept     = s_valid && s_ready;
   assign k          = keep_to_count(MAX_BYTES'(s_keep));
   assign core_valid = accept ? s_keep : '0;
   assign core_reset = !reset || (accept && s_last);
   assign dbg_state  = state_q;

   slicing_crc #(
      .SLICE_LENGTH    (DATA_BYTES),
      .INITIAL_CRC     (INITIAL_CRC),
      .INVERT_OUTPUT   (1'b1),
      .REGISTER_OUTPUT (1'b0)
   ) u_crc (
      .clk   (clk),
      .reset (core_reset),
      .data  (s_data),
      .valid (core_valid),
      .crc   (fcs)
   );

   // Build the next output beat and the PASS/TAIL sequencing.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      tail_d    = tail_q;
      load      = 1'b0;
      nxt_data  = '0;
      nxt_keep  = '0;
      nxt_last  = 1'b0;
      last_data = '0;
      fcs_sh    = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (5'(i) < k) begin
            last_data[8*i +: 8] = s_data[8*i +: 8];
         end else if (5'(i) < k + 5'(FCS_BYTES)) begin
            fcs_sh = fcs >> {5'(i) - k, 3'b000};
            last_data[8*i +: 8] = fcs_sh[7:0];
         end
      end
      case (state_q)
         PASS: begin
            if (accept) begin
               load = 1'b1;
               if (!s_last) begin
                  nxt_data = mask_bytes(s_data, s_keep);
                  nxt_keep = s_keep;
               end else if (k + 5'(FCS_BYTES) <= 5'(DATA_BYTES)) begin
                  nxt_data = last_data;
                  nxt_keep = keep_mask(k + 5'(FCS_BYTES));
                  nxt_last = 1'b1;
               end else begin
                  // FCS spills over: keep the bytes that did not fit.
                  nxt_data = last_data;
                  nxt_keep = '1;
                  hold_d   = fcs >> {5'(DATA_BYTES) - k, 3'b000};
                  tail_d   = k + 5'(FCS_BYTES) - 5'(DATA_BYTES);
                  state_d  = TAIL;
               end
            end
         end
         TAIL: begin
            if (load_en) begin
               load     = 1'b1;
               nxt_keep = keep_mask(tail_q);
               nxt_data = mask_bytes(DW'(hold_q), nxt_keep);
               nxt_last = 1'b1;
               state_d  = PASS;
            end
         end
         default: state_d = PASS;
      endcase
   end

   // State, spill-over FCS bytes and the registered output stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= PASS;
         hold_q      <= '0;
         tail_q      <= '0;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         m_keep      <= '0;
         m_data      <= '0;
         frame_count <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         tail_q  <= tail_d;
         if (load) begin
            m_valid <= 1'b1;
            m_data  <= nxt_data;
            m_keep  <= nxt_keep;
            m_last  <= nxt_last;
            if (nxt_last) frame_count <= frame_count + 32'd1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   // Sticky flag for malformed byte enables on accepted beats.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         keep_error <= 1'b0;
      end else if (accept && (!keep_contiguous(MAX_BYTES'(s_keep)) ||
                              (s_keep != '1 && !s_last))) begin
         keep_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_crc_fcs_inserter.sv
// Directed bench for crc_fcs_inserter with DATA_BYTES=8.
module tb_crc_fcs_inserter;
   import crc_stream_pkg::*;

   localparam int DB = 8;
   localparam int BW = 1 + DB + 8*DB;

   localparam logic [63:0] D_1TO8  = 64'h3837363534333231;   // "12345678"
   localparam logic [63:0] D_9     = 64'h0000000000000039;   // "9"
   localparam logic [63:0] D_9FCS  = 64'h000000CBF4392639;   // "9" + FCS of "123456789"

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [8*DB-1:0] s_data = '0;
   logic [DB-1:0]   s_keep = '0;
   logic            s_valid = 1'b0;
   logic            s_last = 1'b0;
   logic            s_ready;
   logic [8*DB-1:0] m_data;
   logic [DB-1:0]   m_keep;
   logic            m_valid;
   logic            m_last;
   logic            m_ready = 1'b1;
   logic [31:0]     frame_count;
   logic            keep_error;
   state_t          dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] got_q[$];

   crc_fcs_inserter #(.DATA_BYTES(DB), .INITIAL_CRC(32'hFFFFFFFF)) dut (
      .clk         (clk),
      .reset       (reset),
      .s_data      (s_data),
      .s_keep      (s_keep),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .m_data      (m_data),
      .m_keep      (m_keep),
      .m_valid     (m_valid),
      .m_last      (m_last),
      .m_ready     (m_ready),
      .frame_count (frame_count),
      .keep_error  (keep_error),
      .dbg_state   (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // monitor: inputs change just after posedge, so negedge sees the handshake
   always @(negedge clk) begin
      if (reset && m_valid && m_ready) got_q.push_back({m_last, m_keep, m_data});
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver: called just after a posedge, returns just after the accepting posedge
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int n;
      s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         tests_run++;
         tests_failed++;
         $error("FAIL send_timeout: observed s_ready=0 expected s_ready=1 within 100 cycles");
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic drain();
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic exp_beat(input logic l, input logic [7:0] k, input logic [63:0] d);
      exp_q.push_back({l, k, d});
   endtask

   // scoreboard: compare captured beats against the expected queue in order
   task automatic check_frame(input string tag);
      logic [BW-1:0] e, g;
      int n;
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
         chk($sformatf("%s_beat%0d", tag, n), 96'(g), 96'(e));
         n++;
      end
      chk({tag, "_extra_beats"}, 96'(got_q.size()), 96'd0);
      got_q.delete();
   endtask

   task automatic stall_check(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk({tag, "_valid"}, 96'(m_valid), 96'd1);
         chk({tag, "_data"},  96'(m_data),  96'(d));
         chk({tag, "_keep"},  96'(m_keep),  96'(k));
         chk({tag, "_last"},  96'(m_last),  96'(l));
         chk({tag, "_s_ready"}, 96'(s_ready), 96'd0);
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", 96'(m_valid), 96'd0);
      chk("rst_m_last", 96'(m_last), 96'd0);
      chk("rst_m_keep", 96'(m_keep), 96'd0);
      chk("rst_m_data", 96'(m_data), 96'd0);
      chk("rst_frame_count", 96'(frame_count), 96'd0);
      chk("rst_keep_error", 96'(keep_error), 96'd0);
      chk("rst_s_ready", 96'(s_ready), 96'd0);
      chk("rst_state", 96'(dbg_state), 96'(PASS));
      @(posedge clk); #1;
      reset = 1'b1;

      // "123456789": FCS fits in the last beat
      exp_beat(1'b0, 8'hFF, D_1TO8);
      exp_beat(1'b1, 8'h1F, D_9FCS);
      send_beat(D_1TO8, 8'hFF, 1'b0);
      send_beat(D_9, 8'h01, 1'b1);
      drain();
      check_frame("check9");
      chk("check9_frame_count", 96'(frame_count), 96'd1);

      // 13 bytes ending with its own FCS: CRC is the residue 0x2144DF1C, k=5 spills
      exp_beat(1'b0, 8'hFF, D_1TO8);
      exp_beat(1'b0, 8'hFF, 64'h44DF1CCBF4392639);
      exp_beat(1'b1, 8'h01, 64'h0000000000000021);
      send_beat(D_1TO8, 8'hFF, 1'b0);
      send_beat(D_9FCS, 8'h1F, 1'b1);
      @(negedge clk);
      chk("tail_s_ready", 96'(s_ready), 96'd0);
      chk("tail_state", 96'(dbg_state), 96'(TAIL));
      drain();
      check_frame("tail13");
      chk("tail13_frame_count", 96'(frame_count), 96'd2);

      // zero-byte single-beat frame
      exp_beat(1'b1, 8'h0F, 64'h0);
      send_beat(64'h0, 8'h00, 1'b1);
      drain();
      check_frame("zero");
      chk("zero_frame_count", 96'(frame_count), 96'd3);

      // back-to-back frames, no idle
      exp_beat(1'b0, 8'hFF, D_1TO8);
      exp_beat(1'b1, 8'h1F, D_9FCS);
      exp_beat(1'b0, 8'hFF, D_1TO8);
      exp_beat(1'b1, 8'h1F, D_9FCS);
      send_beat(D_1TO8, 8'hFF, 1'b0);
      send_beat(D_9, 8'h01, 1'b1);
      send_beat(D_1TO8, 8'hFF, 1'b0);
      send_beat(D_9, 8'h01, 1'b1);
      drain();
      check_frame("b2b");
      chk("b2b_frame_count", 96'(frame_count), 96'd5);

      // backpressure mid-frame and during the tail
      exp_beat(1'b0, 8'hFF, D_1TO8);
      exp_beat(1'b0, 8'hFF, 64'h44DF1CCBF4392639);
      exp_beat(1'b1, 8'h01, 64'h0000000000000021);
      m_ready = 1'b0;
      send_beat(D_1TO8, 8'hFF, 1'b0);
      s_data = D_9FCS; s_keep = 8'h1F; s_last = 1'b1; s_valid = 1'b1;
      stall_check("bp_mid", D_1TO8, 8'hFF, 1'b0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume_s_ready", 96'(s_ready), 96'd1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b0;
      stall_check("bp_tail", 64'h44DF1CCBF4392639, 8'hFF, 1'b0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      drain();
      check_frame("bp");
      chk("bp_frame_count", 96'(frame_count), 96'd6);

      // reset after the first beat of a frame
      send_beat(D_1TO8, 8'hFF, 1'b0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_no_output", 96'(got_q.size()), 96'd0);
      chk("abort_frame_count", 96'(frame_count), 96'd0);
      @(posedge clk); #1;
      exp_beat(1'b0, 8'hFF, D_1TO8);
      exp_beat(1'b1, 8'h1F, D_9FCS);
      send_beat(D_1TO8, 8'hFF, 1'b0);
      send_beat(D_9, 8'h01, 1'b1);
      drain();
      check_frame("after_abort");
      chk("after_abort_frame_count", 96'(frame_count), 96'd1);
      chk("after_abort_keep_error", 96'(keep_error), 96'd0);

      // partial keep on a non-last beat raises the sticky flag
      send_beat(D_1TO8, 8'h7F, 1'b0);
      send_beat(D_9, 8'h01, 1'b1);
      drain();
      got_q.delete();
      chk("keep_error_set", 96'(keep_error), 96'd1);
      chk("keep_error_frame_count", 96'(frame_count), 96'd2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
